ls_accum_ctrl: RTL

Sequencer for the least-squares regression stage of the option-pricing engine. It streams N sample pairs (x, y) from the path-sample memory, then drives the X^T X and X^T Y accumulators through a two-stage read/square pipeline. After the last accumulate it hands off to the matrix-inverse/solve unit and reports completion. It also owns accumulator clearing, memory flow control, and abort handling.

---
 rtl/ls_accum_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ls_accum_ctrl.sv
// Least-squares accumulation sequencer: streams N (x, y) samples through a
// two-stage read/square pipeline into the accumulators, then hands off to the solver.
module ls_accum_ctrl #(
  parameter int N_SAMPLES = 1024,
  parameter int ADDR_W    = 10,
  parameter int X_W       = 12,
  parameter int Y_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ready,
  input  logic [X_W-1:0]      mem_x,
  input  logic [Y_W-1:0]      mem_y,
  output logic                acc_clr,
  output logic                acc_en,
  output logic [X_W-1:0]      acc_x,
  output logic [2*X_W-1:0]    acc_x2,
  output logic [Y_W-1:0]      acc_y,
  output logic [ADDR_W:0]     sample_cnt,
  output logic                inv_start,
  input  logic                inv_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_DRAIN = 3'd3,
    S_SOLVE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  state_t             state_r;
  logic               rd_vld_r;     // a read was accepted last cycle; its data is on mem_x/mem_y now
  logic [1:0]         drain_cnt_r;
  logic [2*X_W-1:0]   x_sq_s;

  assign x_sq_s = {{X_W{1'b0}}, mem_x} * {{X_W{1'b0}}, mem_x};

  // Read strobe follows memory flow control while fetching.
  always_comb begin
    if (state_r == S_FETCH) begin
      mem_rd_en = mem_ready;
    end else begin
      mem_rd_en = 1'b0;
    end
  end

  // Sequencer state, read pipeline and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      rd_vld_r    <= 1'b0;
      drain_cnt_r <= 2'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_addr    <= '0;
      acc_clr     <= 1'b0;
      acc_en      <= 1'b0;
      acc_x       <= '0;
      acc_x2      <= '0;
      acc_y       <= '0;
      sample_cnt  <= '0;
      inv_start   <= 1'b0;
    end else begin
      acc_clr   <= 1'b0;
      inv_start <= 1'b0;
      done      <= 1'b0;
      if (abort && (state_r != S_IDLE)) begin
        // Flushing both valid bits guarantees no accumulate after the abort cycle.
        state_r  <= S_IDLE;
        busy     <= 1'b0;
        rd_vld_r <= 1'b0;
        acc_en   <= 1'b0;
      end else begin
        rd_vld_r <= mem_rd_en;
        acc_en   <= rd_vld_r;
        if (rd_vld_r) begin
          acc_x      <= mem_x;
          acc_x2     <= x_sq_s;
          acc_y      <= mem_y;
          sample_cnt <= sample_cnt + (ADDR_W+1)'(1);
        end else begin
          sample_cnt <= sample_cnt;
        end
        if (mem_rd_en && (mem_addr != LAST_ADDR)) begin
          mem_addr <= mem_addr + ADDR_W'(1);
        end else begin
          mem_addr <= mem_addr;
        end
        case (state_r)
          S_IDLE: begin
            if (go) begin
              state_r <= S_CLEAR;
              busy    <= 1'b1;
              acc_clr <= 1'b1;
            end else begin
              state_r <= S_IDLE;
            end
          end
          S_CLEAR: begin
            state_r    <= S_FETCH;
            mem_addr   <= '0;
            sample_cnt <= '0;
          end
          S_FETCH: begin
            if (mem_rd_en && (mem_addr == LAST_ADDR)) begin
              state_r     <= S_DRAIN;
              drain_cnt_r <= 2'd0;
            end else begin
              state_r <= S_FETCH;
            end
          end
          S_DRAIN: begin
            if (drain_cnt_r == 2'd1) begin
              state_r   <= S_SOLVE;
              inv_start <= 1'b1;
            end else begin
              drain_cnt_r <= drain_cnt_r + 2'd1;
            end
          end
          S_SOLVE: begin
            // inv_start is high only on the first SOLVE cycle, where inv_done is ignored.
            if (!inv_start && inv_done) begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_r <= S_SOLVE;
            end
          end
          S_DONE: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
